stall_ctrl: RTL and testbench
=============================

# stall_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It decides each cycle whether the F/D pipeline registers hold and whether the E register is flushed to a bubble. Stall sources are register read-after-write hazards (Tuse/Tnew scheme) and the multi-cycle multiply/divide unit (MDU), whose busy window this block sequences with an internal counter. It also keeps a saturating stall-cycle performance counter.

## Interface
- MULT_CYC, 5, busy cycles after a mult/multu issues from E
- DIV_CYC, 10, busy cycles after a div/divu issues from E
- CNT_W, 4, width of MDU busy counter (must hold DIV_CYC)
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low reset (sampled on rising edge of Clk; 0 = reset)
- RsD  in  5  rs field of instruction in D
- RtD  in  5  rt field of instruction in D
- TuseRsD  in  2  cycles until D needs rs (3 = not used)
- TuseRtD  in  2  cycles until D needs rt (3 = not used)
- A3E  in  5  destination register of instruction in E (0 = none)
- TnewE  in  2  cycles until E result is available
- A3M  in  5  destination register of instruction in M (0 = none)
- TnewM  in  2  cycles until M result is available
- MdStartE  in  1  mult/multu/div/divu is in E this cycle
- MdDivE  in  1  qualifies MdStartE: 1 = divide, 0 = multiply
- MdUseD  in  1  D holds mult/div/mfhi/mflo/mthi/mtlo
- StallF  out  1  hold PC
- StallD  out  1  hold D register
- FlushE  out  1  load bubble (all-zero) into E register
- MdBusy  out  1  MDU busy counter nonzero
- StallCnt  out  32  total stalled cycles since reset, saturating

## Operation
- Data hazard, rs: RsD != 0 and RsD == A3E and TuseRsD < TnewE; same test against A3M/TnewM.
- Data hazard, rt: same as rs, using RtD/TuseRtD.
- MD hazard: MdUseD and (MdStartE or MdBusy).
- Stall = any data hazard or MD hazard; StallF = StallD = FlushE = Stall.
- All three outputs are combinational from the inputs and the current state.
- MDU FSM states:
  - IDLE (count = 0).
  - BUSY (count > 0).
  - IDLE -> BUSY on MdStartE. Count loads DIV_CYC if MdDivE, else MULT_CYC.
  - BUSY: count decrements by 1 each cycle. BUSY -> IDLE when count reaches 0.
- MdBusy = (count != 0), registered.
- MdStartE while already BUSY is a protocol violation that cannot occur, because the MD stall blocks issue. If it does occur, it is ignored and the count continues decrementing.
- StallCnt increments by 1 on every cycle where Stall = 1 and Reset = 1. It holds at 32'hFFFFFFFF (no wrap).
- While Reset = 0: Stall, StallF, StallD and FlushE are forced to 0.

## Timing
- Reset values: count = 0, MdBusy = 0, StallCnt = 0, StallF = StallD = FlushE = 0.
- Reset asserted mid-operation clears count immediately at the next edge. MdBusy is 0 the following cycle, regardless of the remaining count.
- Data-hazard stall has zero-cycle latency: asserted in the same cycle the hazard condition is present.
- MDU latency:
  - MdStartE high in cycle t -> MdBusy high in cycles t+1 .. t+N, where N = MULT_CYC or DIV_CYC; low in t+N+1.
  - A dependent MdUseD instruction stalls in cycles t .. t+N and advances from D in cycle t+N+1.
- A new MdStartE in the same cycle that count decrements to 0 reloads the count. This gives back-to-back operations with no idle gap.
- StallCnt updates one cycle after the stalled cycle (registered).

## Test plan
- Reset low 2 cycles, then high with all inputs 0:
  - StallF/StallD/FlushE = 0, MdBusy = 0, StallCnt = 0.
- Load-use:
  - Inputs: A3E=5, TnewE=2, RsD=5, TuseRsD=1.
  - Stall = 1 that cycle. With TnewE=1 next cycle, Stall = 0. StallCnt = 1.
- $0 and unused operand:
  - A3E=0, RsD=0, TnewE=2, TuseRsD=0 -> no stall.
  - RtD=A3E=7, TuseRtD=3, TnewE=2 -> no stall.
- Div then mflo:
  - MdStartE=1, MdDivE=1 at t, MdUseD=1 held.
  - Stall in t..t+10; MdBusy high t+1..t+10; Stall = 0 at t+11; StallCnt = 11.
- Mult with reset mid-busy:
  - MdStartE=1, MdDivE=0 at t; Reset=0 at t+2.
  - MdBusy = 0 from t+3; StallCnt = 0; after release, MdUseD alone gives no stall.
- Saturation:
  - Force StallCnt to 32'hFFFFFFFE via a long hazard (or backdoor), then hold the hazard 3 cycles.
  - StallCnt reaches 32'hFFFFFFFF and stays there.

Source files
------------

// File: rtl/stall_ctrl_if.sv
// Hazard/stall controller signal bundle: operand and destination info
// from the D/E/M stages and MDU issue, plus the stall/flush controls back.
interface stall_ctrl_if;
  logic [4:0] RsD;
  logic [4:0] RtD;
  logic [1:0] TuseRsD;
  logic [1:0] TuseRtD;
  logic [4:0] A3E;
  logic [1:0] TnewE;
  logic [4:0] A3M;
  logic [1:0] TnewM;
  logic       MdStartE;
  logic       MdDivE;
  logic       MdUseD;
  logic       StallF;
  logic       StallD;
  logic       FlushE;
  logic       MdBusy;
  logic [31:0] StallCnt;

  modport master (
    output RsD, RtD, TuseRsD, TuseRtD, A3E, TnewE, A3M, TnewM,
           MdStartE, MdDivE, MdUseD,
    input  StallF, StallD, FlushE, MdBusy, StallCnt
  );

  modport slave (
    input  RsD, RtD, TuseRsD, TuseRtD, A3E, TnewE, A3M, TnewM,
           MdStartE, MdDivE, MdUseD,
    output StallF, StallD, FlushE, MdBusy, StallCnt
  );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline hazard and stall controller for the five-stage core.
// Decides F/D hold and E flush from Tuse/Tnew data hazards and the MDU
// busy window, and keeps a saturating count of stalled cycles.
//
// state  | meaning
// S_IDLE | MDU free, busy counter is 0
// S_BUSY | MDU running, counter holds remaining busy cycles (> 0)
module stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,   // synchronous, active-low
  stall_ctrl_if.slave  if_hz
);

  localparam logic [CNT_W-1:0] L_MULT = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_md_busy;
  logic [31:0]      r_stall_cnt;

  logic             w_hz_rs;
  logic             w_hz_rt;
  logic             w_hz_md;
  logic             w_stall;
  logic [CNT_W-1:0] w_load;

  // Operand hazards: a nonzero source matching a producer whose result
  // arrives later than the consumer needs it. Tuse=3 never beats any Tnew.
  always_comb begin
    w_hz_rs = (if_hz.RsD != 5'd0) &&
              (((if_hz.RsD == if_hz.A3E) && (if_hz.TuseRsD < if_hz.TnewE)) ||
               ((if_hz.RsD == if_hz.A3M) && (if_hz.TuseRsD < if_hz.TnewM)));
    w_hz_rt = (if_hz.RtD != 5'd0) &&
              (((if_hz.RtD == if_hz.A3E) && (if_hz.TuseRtD < if_hz.TnewE)) ||
               ((if_hz.RtD == if_hz.A3M) && (if_hz.TuseRtD < if_hz.TnewM)));
    w_hz_md = if_hz.MdUseD && (if_hz.MdStartE || r_md_busy);
    w_stall = i_reset && (w_hz_rs || w_hz_rt || w_hz_md);
  end

  assign w_load = if_hz.MdDivE ? L_DIV : L_MULT;

  // MDU busy sequencer; a start while busy is ignored except on the last
  // busy cycle, where it reloads so back-to-back ops have no idle gap.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_md_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (if_hz.MdStartE) begin
            r_state   <= S_BUSY;
            r_count   <= w_load;
            r_md_busy <= 1'b1;
          end
        end
        S_BUSY: begin
          if (r_count == L_ONE) begin
            if (if_hz.MdStartE) begin
              r_count <= w_load;
            end else begin
              r_state   <= S_IDLE;
              r_count   <= '0;
              r_md_busy <= 1'b0;
            end
          end else begin
            r_count <= r_count - L_ONE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_count   <= '0;
          r_md_busy <= 1'b0;
        end
      endcase
    end
  end

  // Saturating stalled-cycle counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign if_hz.StallF   = w_stall;
  assign if_hz.StallD   = w_stall;
  assign if_hz.FlushE   = w_stall;
  assign if_hz.MdBusy   = r_md_busy;
  assign if_hz.StallCnt = r_stall_cnt;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: expected outputs per cycle go into a
// scoreboard queue and are popped and compared mid-cycle.
module tb_stall_ctrl;

  logic i_clk;
  logic i_reset;

  stall_ctrl_if intf ();

  stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .if_hz   (intf.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_checks;
  int          n_errors;
  logic [31:0] exp_cnt;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    n_checks++;
    assert (obs === e.val) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  // One cycle: queue expectations, compare at negedge, then advance the
  // reference stall counter across the rising edge.
  task automatic cyc(input string tag, input logic exp_stall, input logic exp_busy);
    push({tag, ".StallF"},   {31'd0, exp_stall});
    push({tag, ".StallD"},   {31'd0, exp_stall});
    push({tag, ".FlushE"},   {31'd0, exp_stall});
    push({tag, ".MdBusy"},   {31'd0, exp_busy});
    push({tag, ".StallCnt"}, exp_cnt);
    @(negedge i_clk);
    pop_check({31'd0, intf.StallF});
    pop_check({31'd0, intf.StallD});
    pop_check({31'd0, intf.FlushE});
    pop_check({31'd0, intf.MdBusy});
    pop_check(intf.StallCnt);
    @(posedge i_clk);
    if (!i_reset) exp_cnt = 32'd0;
    else if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    #1;
  endtask

  task automatic clear_inputs();
    intf.RsD = 5'd0; intf.RtD = 5'd0;
    intf.TuseRsD = 2'd0; intf.TuseRtD = 2'd0;
    intf.A3E = 5'd0; intf.TnewE = 2'd0;
    intf.A3M = 5'd0; intf.TnewM = 2'd0;
    intf.MdStartE = 1'b0; intf.MdDivE = 1'b0; intf.MdUseD = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 32'd0;
    clear_inputs();
    i_reset = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;

    // Reset state
    cyc("reset", 1'b0, 1'b0);

    // Load-use on rs against E, then producer ready
    intf.A3E = 5'd5; intf.TnewE = 2'd2; intf.RsD = 5'd5; intf.TuseRsD = 2'd1;
    cyc("load_use", 1'b1, 1'b0);
    intf.TnewE = 2'd1;
    cyc("load_use_ok", 1'b0, 1'b0);

    // $0 never hazards
    clear_inputs();
    intf.TnewE = 2'd2;
    cyc("zero_reg", 1'b0, 1'b0);

    // Unused rt operand
    clear_inputs();
    intf.RtD = 5'd7; intf.A3E = 5'd7; intf.TuseRtD = 2'd3; intf.TnewE = 2'd2;
    cyc("rt_unused", 1'b0, 1'b0);

    // rt hazard against M stage; equal Tuse/Tnew does not stall
    clear_inputs();
    intf.RtD = 5'd9; intf.A3M = 5'd9; intf.TnewM = 2'd1; intf.TuseRtD = 2'd0;
    cyc("rt_m_haz", 1'b1, 1'b0);
    intf.TuseRtD = 2'd1;
    cyc("rt_m_equal", 1'b0, 1'b0);

    // Divide followed by dependent mflo
    clear_inputs();
    intf.MdStartE = 1'b1; intf.MdDivE = 1'b1; intf.MdUseD = 1'b1;
    cyc("div_t0", 1'b1, 1'b0);
    intf.MdStartE = 1'b0; intf.MdDivE = 1'b0;
    for (int i = 1; i <= 10; i++) cyc("div_busy", 1'b1, 1'b1);
    cyc("div_done", 1'b0, 1'b0);

    // Back-to-back multiplies: restart on the last busy cycle
    clear_inputs();
    intf.MdStartE = 1'b1;
    cyc("b2b_t0", 1'b0, 1'b0);
    intf.MdStartE = 1'b0;
    for (int i = 1; i <= 4; i++) cyc("b2b_first", 1'b0, 1'b1);
    intf.MdStartE = 1'b1;
    cyc("b2b_reload", 1'b0, 1'b1);
    intf.MdStartE = 1'b0;
    for (int i = 1; i <= 5; i++) cyc("b2b_second", 1'b0, 1'b1);
    cyc("b2b_idle", 1'b0, 1'b0);

    // Multiply with reset asserted mid-busy
    intf.MdStartE = 1'b1; intf.MdDivE = 1'b0; intf.MdUseD = 1'b1;
    cyc("mrst_t0", 1'b1, 1'b0);
    intf.MdStartE = 1'b0;
    cyc("mrst_t1", 1'b1, 1'b1);
    i_reset = 1'b0;
    cyc("mrst_in_reset", 1'b0, 1'b1);
    i_reset = 1'b1;
    cyc("mrst_released", 1'b0, 1'b0);
    cyc("mrst_md_alone", 1'b0, 1'b0);

    // Saturation: preload the counter near the top, hold a hazard
    clear_inputs();
    intf.A3E = 5'd5; intf.TnewE = 2'd2; intf.RsD = 5'd5; intf.TuseRsD = 2'd1;
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    exp_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) cyc("sat", 1'b1, 1'b0);
    clear_inputs();
    cyc("sat_hold", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
